spatial_filter_3x3: RTL and testbench

// - Streaming 3x3 mean (box-blur) filter for 8-bit grayscale images, fed row by row.
// - Holds image rows in four circular line buffers and slides a 3x3 window across three buffered rows.
// - Sends filtered pixels through an output FIFO.
// - Raises an interrupt each time a row has been consumed, so the host DMA/CPU knows to send the next row.

---
 rtl/spatial_filter_3x3.sv | 198 +++++++++++++++++++
 tb/tb_spatial_filter_3x3.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/spatial_filter_3x3.sv
// Streaming 3x3 box-blur for 8-bit grayscale rows: four circular line buffers,
// a two-stage window/sum pipeline and a first-word-fall-through output FIFO.
module spatial_filter_3x3 #(
    parameter int IMAGE_WIDTH = 512,
    parameter int FIFO_DEPTH  = 32
) (
    input  logic       axis_clk,
    input  logic       axis_reset,
    input  logic       i_s_data_valid,
    input  logic [7:0] i_s_data,
    output logic       o_s_ready,
    output logic       o_m_data_valid,
    output logic [7:0] o_m_data,
    input  logic       i_m_ready,
    output logic       o_intr
);
    // state   | meaning
    // ST_IDLE | waiting for three unconsumed rows
    // ST_READ | sliding the window across one output row (stalls on FIFO almost-full)

    localparam int PW  = $clog2(IMAGE_WIDTH);
    localparam int CW  = $clog2(4 * IMAGE_WIDTH + 1);
    localparam int FAW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0]  CNT_FULL  = CW'(4 * IMAGE_WIDTH);
    localparam logic [CW-1:0]  CNT_ROWS3 = CW'(3 * IMAGE_WIDTH);
    localparam logic [PW-1:0]  PTR_LAST  = PW'(IMAGE_WIDTH - 1);
    localparam logic [FAW:0]   AF_LEVEL  = (FAW + 1)'(FIFO_DEPTH - 4);
    localparam logic [FAW:0]   FIFO_FULL = (FAW + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_READ} rd_state_t;

    rd_state_t       state, next_state;
    logic [7:0]      line_buf [4][IMAGE_WIDTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [1:0]      wr_buf, rd_buf;
    logic [CW-1:0]   pix_cnt;
    logic            wr_en, rd_en, row_done;
    logic [1:0]      line_sel [3];
    logic [PW-1:0]   col_sel [3];
    logic [7:0]      win [9];
    logic            win_valid;
    logic [11:0]     win_sum;
    logic [7:0]      res_data;
    logic            res_valid;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [FAW-1:0]  fifo_wr_ptr, fifo_rd_ptr;
    logic [FAW:0]    fifo_cnt;
    logic            fifo_almost_full, push, pop;

    assign fifo_almost_full = fifo_cnt >= AF_LEVEL;
    assign o_s_ready        = (pix_cnt < CNT_FULL) && !fifo_almost_full;
    assign wr_en            = i_s_data_valid && o_s_ready;

    // Write side
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            wr_ptr <= '0;
            wr_buf <= '0;
        end else if (wr_en) begin
            if (wr_ptr == PTR_LAST) begin
                wr_ptr <= '0;
                wr_buf <= wr_buf + 2'd1;
            end else begin
                wr_ptr <= wr_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (wr_en)
            line_buf[wr_buf][wr_ptr] <= i_s_data;
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset)
            pix_cnt <= '0;
        else if (wr_en && !rd_en)
            pix_cnt <= pix_cnt + CW'(1);
        else if (!wr_en && rd_en)
            pix_cnt <= pix_cnt - CW'(1);
    end

    // Read FSM
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        row_done   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pix_cnt >= CNT_ROWS3)
                    next_state = ST_READ;
            end
            ST_READ: begin
                if (!fifo_almost_full) begin
                    rd_en = 1'b1;
                    if (rd_ptr == PTR_LAST) begin
                        row_done   = 1'b1;
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            rd_ptr <= '0;
            rd_buf <= '0;
            o_intr <= 1'b0;
        end else begin
            o_intr <= row_done;
            if (row_done) begin
                rd_ptr <= '0;
                rd_buf <= rd_buf + 2'd1;
            end else if (rd_en) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Window columns wrap onto the start of the same line; no padding
    always_comb begin
        line_sel[0] = rd_buf;
        line_sel[1] = rd_buf + 2'd1;
        line_sel[2] = rd_buf + 2'd2;
        col_sel[0]  = rd_ptr;
        col_sel[1]  = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
        col_sel[2]  = (col_sel[1] == PTR_LAST) ? '0 : col_sel[1] + PW'(1);
    end

    always_ff @(posedge axis_clk) begin
        if (rd_en) begin
            for (int l = 0; l < 3; l++)
                for (int k = 0; k < 3; k++)
                    win[3*l+k] <= line_buf[line_sel[l]][col_sel[k]];
        end
    end

    always_comb begin
        win_sum = '0;
        for (int i = 0; i < 9; i++)
            win_sum = win_sum + {4'd0, win[i]};
    end

    always_ff @(posedge axis_clk) begin
        if (win_valid)
            res_data <= 8'(win_sum / 12'd9);
    end

    // Only the valid flags need clearing for reset to discard in-flight results
    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            win_valid <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            win_valid <= rd_en;
            res_valid <= win_valid;
        end
    end

    // Output FIFO
    assign o_m_data_valid = fifo_cnt != '0;
    assign o_m_data       = o_m_data_valid ? fifo_mem[fifo_rd_ptr] : 8'd0;
    assign push           = res_valid && (fifo_cnt != FIFO_FULL);
    assign pop            = o_m_data_valid && i_m_ready;

    always_ff @(posedge axis_clk) begin
        if (push)
            fifo_mem[fifo_wr_ptr] <= res_data;
    end

    always_ff @(posedge axis_clk or posedge axis_reset) begin
        if (axis_reset) begin
            fifo_wr_ptr <= '0;
            fifo_rd_ptr <= '0;
            fifo_cnt    <= '0;
        end else begin
            if (push)
                fifo_wr_ptr <= fifo_wr_ptr + FAW'(1);
            if (pop)
                fifo_rd_ptr <= fifo_rd_ptr + FAW'(1);
            if (push && !pop)
                fifo_cnt <= fifo_cnt + (FAW + 1)'(1);
            else if (!push && pop)
                fifo_cnt <= fifo_cnt - (FAW + 1)'(1);
        end
    end

endmodule

// File: tb/tb_spatial_filter_3x3.sv
// Directed bench for spatial_filter_3x3 at IMAGE_WIDTH=8 with hand-computed expected pixels.
module tb_spatial_filter_3x3;
    localparam int W = 8;

    logic       axis_clk = 1'b0;
    logic       axis_reset = 1'b1;
    logic       i_s_data_valid = 1'b0;
    logic [7:0] i_s_data = 8'd0;
    logic       o_s_ready;
    logic       o_m_data_valid;
    logic [7:0] o_m_data;
    logic       i_m_ready = 1'b1;
    logic       o_intr;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] out_q[$];
    int         intr_cnt = 0;
    logic       intr_prev = 1'b0;
    logic       intr_long = 1'b0;
    logic       ready_dropped = 1'b0;

    int exp_ramp[16] = '{11, 12, 13, 14, 15, 16, 14, 12,
                         21, 22, 23, 24, 25, 26, 24, 22};
    int exp_spot[8]  = '{0, 28, 28, 28, 0, 0, 0, 0};

    spatial_filter_3x3 #(.IMAGE_WIDTH(W), .FIFO_DEPTH(32)) dut (
        .axis_clk       (axis_clk),
        .axis_reset     (axis_reset),
        .i_s_data_valid (i_s_data_valid),
        .i_s_data       (i_s_data),
        .o_s_ready      (o_s_ready),
        .o_m_data_valid (o_m_data_valid),
        .o_m_data       (o_m_data),
        .i_m_ready      (i_m_ready),
        .o_intr         (o_intr)
    );

    always #5 axis_clk = ~axis_clk;

    always @(negedge axis_clk) begin
        if (o_m_data_valid && i_m_ready)
            out_q.push_back(o_m_data);
        if (o_intr)
            intr_cnt++;
        if (o_intr && intr_prev)
            intr_long = 1'b1;
        intr_prev = o_intr;
        if (!axis_reset && !o_s_ready)
            ready_dropped = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic do_reset();
        @(posedge axis_clk);
        #2 axis_reset = 1'b1;
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        axis_reset = 1'b0;
        out_q.delete();
        intr_cnt      = 0;
        intr_long     = 1'b0;
        ready_dropped = 1'b0;
        @(posedge axis_clk);
        #1;
    endtask

    // Half-rate input pacing keeps the reader ahead of the writer across row boundaries
    task automatic send_pixel(input logic [7:0] v);
        int t = 0;
        while (!o_s_ready && t < 500) begin
            @(posedge axis_clk);
            #1;
            t++;
        end
        if (!o_s_ready) begin
            chk("send_ready", o_s_ready, 1'b1);
            return;
        end
        i_s_data       = v;
        i_s_data_valid = 1'b1;
        @(posedge axis_clk);
        #1 i_s_data_valid = 1'b0;
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send_const_row(input logic [7:0] v);
        for (int c = 0; c < W; c++)
            send_pixel(v);
    endtask

    task automatic wait_outputs(input string tag, input int n);
        int t = 0;
        while (out_q.size() < n && t < 2000) begin
            @(posedge axis_clk);
            t++;
        end
        repeat (20) @(posedge axis_clk);
        #1;
        chk(tag, out_q.size(), n);
    endtask

    initial begin
        #3;
        chk("rst_valid", o_m_data_valid, 1'b0);
        chk("rst_data", o_m_data, 8'd0);
        chk("rst_intr", o_intr, 1'b0);
        chk("rst_ready", o_s_ready, 1'b1);
        do_reset();

        // Constant image: three rows of 90 give one output row
        for (int r = 0; r < 3; r++)
            send_const_row(8'd90);
        wait_outputs("const_count", W);
        for (int i = 0; i < W && i < out_q.size(); i++)
            chk($sformatf("const_px%0d", i), out_q[i], 8'd90);
        chk("const_intr", intr_cnt, 1);
        chk("const_ready_held", ready_dropped, 1'b0);

        // Ramp: pixel = 10*row + col, four rows give two output rows
        do_reset();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < W; c++)
                send_pixel(8'(10 * r + c));
        wait_outputs("ramp_count", 16);
        for (int i = 0; i < 16 && i < out_q.size(); i++)
            chk($sformatf("ramp_px%0d", i), out_q[i], exp_ramp[i]);
        chk("ramp_intr", intr_cnt, 2);

        // Saturation: all 255
        do_reset();
        for (int r = 0; r < 3; r++)
            send_const_row(8'd255);
        wait_outputs("sat_count", W);
        for (int i = 0; i < W && i < out_q.size(); i++)
            chk($sformatf("sat_px%0d", i), out_q[i], 8'd255);

        // Single 255 at row 1 col 3: floor(255/9) in windows starting at cols 1..3
        do_reset();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                send_pixel((r == 1 && c == 3) ? 8'd255 : 8'd0);
        wait_outputs("spot_count", W);
        for (int i = 0; i < W && i < out_q.size(); i++)
            chk($sformatf("spot_px%0d", i), out_q[i], exp_spot[i]);

        // Backpressure: rows of 10..60 give output rows of 20,30,40,50
        do_reset();
        i_m_ready = 1'b0;
        for (int r = 0; r < 6; r++)
            send_const_row(8'(10 * (r + 1)));
        for (int t = 0; t < 300 && !ready_dropped; t++)
            @(posedge axis_clk);
        repeat (20) @(posedge axis_clk);
        #1;
        chk("bp_ready_low", ready_dropped, 1'b1);
        chk("bp_no_pop", out_q.size(), 0);
        i_m_ready = 1'b1;
        wait_outputs("bp_count", 32);
        for (int i = 0; i < 32 && i < out_q.size(); i++)
            chk($sformatf("bp_px%0d", i), out_q[i], 20 + 10 * (i / W));
        chk("bp_intr", intr_cnt, 4);
        chk("intr_width", intr_long, 1'b0);

        // Mid-stream reset with results waiting in the FIFO
        do_reset();
        i_m_ready = 1'b0;
        for (int r = 0; r < 3; r++)
            send_const_row(8'd50);
        for (int t = 0; t < 200 && !o_m_data_valid; t++)
            @(posedge axis_clk);
        repeat (3) @(posedge axis_clk);
        #1;
        chk("pre_rst_valid", o_m_data_valid, 1'b1);
        #1 axis_reset = 1'b1;
        #1;
        chk("mid_rst_valid", o_m_data_valid, 1'b0);
        chk("mid_rst_data", o_m_data, 8'd0);
        chk("mid_rst_intr", o_intr, 1'b0);
        chk("mid_rst_ready", o_s_ready, 1'b1);
        @(negedge axis_clk);
        axis_reset = 1'b0;
        out_q.delete();
        i_m_ready = 1'b1;
        repeat (20) @(posedge axis_clk);
        #1;
        chk("post_rst_empty", o_m_data_valid, 1'b0);
        chk("post_rst_no_out", out_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
